// File: rtl/alu_stage.sv
// Single-issue integer execute stage: computes result, branch outcome and next PC
// for one RV32I instruction per cycle and broadcasts it for one cycle.
module alu_stage #(
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 alu_en,
    input  logic [6:0]           alu_opcode,
    input  logic [2:0]           alu_func3,
    input  logic                 alu_func1,
    input  logic [DATA_W-1:0]    alu_val1,
    input  logic [DATA_W-1:0]    alu_val2,
    input  logic [DATA_W-1:0]    alu_imm,
    input  logic [31:0]          alu_pc,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    output logic                 result,
    output logic [ROB_POS_W-1:0] result_rob_pos,
    output logic [DATA_W-1:0]    result_val,
    output logic                 result_jump,
    output logic [31:0]          result_pc
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] val_nxt;
    logic              jump_nxt;
    logic [31:0]       pc_nxt;
    logic [31:0]       pc_plus4;
    logic [31:0]       pc_plus_imm;
    logic [31:0]       jalr_tgt;
    logic              br_eq;
    logic              br_lt;
    logic              br_ltu;
    logic              br_taken;

    assign pc_plus4    = alu_pc + 32'd4;
    assign pc_plus_imm = alu_pc + 32'(alu_imm);
    assign jalr_tgt    = 32'(alu_val1 + alu_imm);

    always_comb begin
        op_a  = alu_val1;
        op_b  = (alu_opcode == OPC_OP) ? alu_val2 : alu_imm;
        shamt = op_b[4:0];
        case (alu_func3)
            3'b000:  alu_out = (alu_opcode == OPC_OP && alu_func1) ? op_a - op_b : op_a + op_b;
            3'b001:  alu_out = op_a << shamt;
            3'b010:  alu_out = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b011:  alu_out = {{(DATA_W-1){1'b0}}, op_a < op_b};
            3'b100:  alu_out = op_a ^ op_b;
            3'b101:  alu_out = alu_func1 ? DATA_W'($signed(op_a) >>> shamt) : op_a >> shamt;
            3'b110:  alu_out = op_a | op_b;
            default: alu_out = op_a & op_b;
        endcase
    end

    // Branch compares always use rs1/rs2, never the immediate.
    always_comb begin
        br_eq  = (alu_val1 == alu_val2);
        br_lt  = ($signed(alu_val1) < $signed(alu_val2));
        br_ltu = (alu_val1 < alu_val2);
        case (alu_func3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        val_nxt  = '0;
        jump_nxt = 1'b0;
        pc_nxt   = pc_plus4;
        case (alu_opcode)
            OPC_OP, OPC_OP_IMM: val_nxt = alu_out;
            OPC_LUI:            val_nxt = alu_imm;
            OPC_AUIPC:          val_nxt = DATA_W'(pc_plus_imm);
            OPC_JAL: begin
                val_nxt  = DATA_W'(pc_plus4);
                jump_nxt = 1'b1;
                pc_nxt   = pc_plus_imm;
            end
            OPC_JALR: begin
                val_nxt  = DATA_W'(pc_plus4);
                jump_nxt = 1'b1;
                pc_nxt   = jalr_tgt & ~32'd1;
            end
            OPC_BRANCH: begin
                jump_nxt = br_taken;
                pc_nxt   = br_taken ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

    // Idle or squashed cycles clear only the valid bit; payload holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            result         <= 1'b0;
            result_rob_pos <= '0;
            result_val     <= '0;
            result_jump    <= 1'b0;
            result_pc      <= '0;
        end else if (rdy) begin
            if (rollback) begin
                result <= 1'b0;
            end else begin
                result <= alu_en;
                if (alu_en) begin
                    result_rob_pos <= alu_rob_pos;
                    result_val     <= val_nxt;
                    result_jump    <= jump_nxt;
                    result_pc      <= pc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Directed testbench for alu_stage: inputs driven and outputs checked on negedge.
module tb_alu_stage;

    localparam int ROB_POS_W = 4;
    localparam int DATA_W    = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPI    = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rdy;
    logic                 rollback;
    logic                 alu_en;
    logic [6:0]           alu_opcode;
    logic [2:0]           alu_func3;
    logic                 alu_func1;
    logic [DATA_W-1:0]    alu_val1;
    logic [DATA_W-1:0]    alu_val2;
    logic [DATA_W-1:0]    alu_imm;
    logic [31:0]          alu_pc;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic                 result;
    logic [ROB_POS_W-1:0] result_rob_pos;
    logic [DATA_W-1:0]    result_val;
    logic                 result_jump;
    logic [31:0]          result_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_stage #(.ROB_POS_W(ROB_POS_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
        .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func1(alu_func1),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob_pos(alu_rob_pos), .result(result), .result_rob_pos(result_rob_pos),
        .result_val(result_val), .result_jump(result_jump), .result_pc(result_pc)
    );

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] pos);
        alu_en = 1'b1; alu_opcode = opc; alu_func3 = f3; alu_func1 = f1;
        alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = pos;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        drive(OP, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h10, 4'd7);
        repeat (2) @(negedge clk);
        total++; if (result !== 1'b0) begin bad++; $display("FAIL rst_result got=%0b exp=0", result); end
        total++; if (result_rob_pos !== 4'd0) begin bad++; $display("FAIL rst_pos got=%0d exp=0", result_rob_pos); end
        total++; if (result_val !== 32'd0) begin bad++; $display("FAIL rst_val got=%h exp=0", result_val); end
        total++; if (result_jump !== 1'b0) begin bad++; $display("FAIL rst_jump got=%0b exp=0", result_jump); end
        total++; if (result_pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", result_pc); end
        rst = 1'b0; alu_en = 1'b0;
        @(negedge clk);
        total++; if (result !== 1'b0) begin bad++; $display("FAIL rst_idle got=%0b exp=0", result); end
    endtask

    task automatic test_sub_addi();
        drive(OP, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'h40, 4'd3);
        @(negedge clk);
        total++; if (result !== 1'b1) begin bad++; $display("FAIL sub_valid got=%0b exp=1", result); end
        total++; if (result_rob_pos !== 4'd3) begin bad++; $display("FAIL sub_pos got=%0d exp=3", result_rob_pos); end
        total++; if (result_val !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_val got=%h exp=fffffffe", result_val); end
        drive(OPI, 3'b000, 1'b1, 32'h500, 32'd0, 32'hFFFFFC00, 32'h40, 4'd4);
        @(negedge clk);
        total++; if (result_val !== 32'h100) begin bad++; $display("FAIL addi_val got=%h exp=100", result_val); end
        total++; if (result_jump !== 1'b0) begin bad++; $display("FAIL addi_jump got=%0b exp=0", result_jump); end
        total++; if (result_pc !== 32'h44) begin bad++; $display("FAIL addi_pc got=%h exp=44", result_pc); end
        alu_en = 1'b0;
    endtask

    task automatic test_shift_cmp();
        drive(OPI, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'd31, 32'h0, 4'd1);
        @(negedge clk);
        total++; if (result_val !== 32'hFFFFFFFF) begin bad++; $display("FAIL sra_val got=%h exp=ffffffff", result_val); end
        drive(OPI, 3'b101, 1'b0, 32'h80000000, 32'd0, 32'd31, 32'h0, 4'd2);
        @(negedge clk);
        total++; if (result_val !== 32'h1) begin bad++; $display("FAIL srl_val got=%h exp=1", result_val); end
        drive(OP, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 4'd3);
        @(negedge clk);
        total++; if (result_val !== 32'h1) begin bad++; $display("FAIL slt_val got=%h exp=1", result_val); end
        drive(OP, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 4'd4);
        @(negedge clk);
        total++; if (result_val !== 32'h0) begin bad++; $display("FAIL sltu_val got=%h exp=0", result_val); end
        alu_en = 1'b0;
    endtask

    task automatic test_branch_jump();
        drive(BRANCH, 3'b001, 1'b0, 32'd5, 32'd5, 32'h20, 32'h100, 4'd5);
        @(negedge clk);
        total++; if (result_jump !== 1'b0) begin bad++; $display("FAIL bne_jump got=%0b exp=0", result_jump); end
        total++; if (result_pc !== 32'h104) begin bad++; $display("FAIL bne_pc got=%h exp=104", result_pc); end
        drive(BRANCH, 3'b101, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h20, 32'h100, 4'd6);
        @(negedge clk);
        total++; if (result_jump !== 1'b1) begin bad++; $display("FAIL bge_jump got=%0b exp=1", result_jump); end
        total++; if (result_pc !== 32'h120) begin bad++; $display("FAIL bge_pc got=%h exp=120", result_pc); end
        total++; if (result_val !== 32'h0) begin bad++; $display("FAIL bge_val got=%h exp=0", result_val); end
        drive(JALR, 3'b000, 1'b0, 32'h203, 32'd0, 32'h0, 32'h100, 4'd7);
        @(negedge clk);
        total++; if (result_val !== 32'h104) begin bad++; $display("FAIL jalr_val got=%h exp=104", result_val); end
        total++; if (result_pc !== 32'h202) begin bad++; $display("FAIL jalr_pc got=%h exp=202", result_pc); end
        total++; if (result_jump !== 1'b1) begin bad++; $display("FAIL jalr_jump got=%0b exp=1", result_jump); end
        drive(JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'h40, 32'h100, 4'd8);
        @(negedge clk);
        total++; if (result_pc !== 32'h140) begin bad++; $display("FAIL jal_pc got=%h exp=140", result_pc); end
        drive(BRANCH, 3'b010, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd9);
        @(negedge clk);
        total++; if (result !== 1'b1) begin bad++; $display("FAIL badbr_valid got=%0b exp=1", result); end
        total++; if (result_jump !== 1'b0) begin bad++; $display("FAIL badbr_jump got=%0b exp=0", result_jump); end
        total++; if (result_pc !== 32'h104) begin bad++; $display("FAIL badbr_pc got=%h exp=104", result_pc); end
        drive(7'b0000000, 3'b000, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd10);
        @(negedge clk);
        total++; if (result_val !== 32'h0) begin bad++; $display("FAIL unk_val got=%h exp=0", result_val); end
        total++; if (result_rob_pos !== 4'd10) begin bad++; $display("FAIL unk_pos got=%0d exp=10", result_rob_pos); end
        alu_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        @(negedge clk);
        total++; if (result !== 1'b1 || result_rob_pos !== 4'd1) begin bad++; $display("FAIL b2b_1 got=%0b/%0d exp=1/1", result, result_rob_pos); end
        drive(OP, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0, 32'h0, 4'd2);
        @(negedge clk);
        total++; if (result !== 1'b1 || result_rob_pos !== 4'd2) begin bad++; $display("FAIL b2b_2 got=%0b/%0d exp=1/2", result, result_rob_pos); end
        drive(OP, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0, 32'h0, 4'd3);
        rollback = 1'b1;
        @(negedge clk);
        total++; if (result !== 1'b0) begin bad++; $display("FAIL b2b_squash got=%0b exp=0", result); end
        rollback = 1'b0; alu_en = 1'b0;
        @(negedge clk);
        total++; if (result !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", result); end
    endtask

    task automatic test_rdy_stall();
        int accepted = 0;
        drive(LUI, 3'b000, 1'b0, 32'd0, 32'd0, 32'h12345000, 32'h0, 4'd5);
        @(negedge clk);
        if (result === 1'b1 && rdy === 1'b1) accepted++;
        rdy = 1'b0; rollback = 1'b1;
        drive(OP, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 32'h0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (result === 1'b1 && rdy === 1'b1) accepted++;
            total++; if (result !== 1'b1 || result_val !== 32'h12345000 || result_rob_pos !== 4'd5) begin
                bad++; $display("FAIL stall_hold%0d got=%0b/%h/%0d exp=1/12345000/5", i, result, result_val, result_rob_pos);
            end
        end
        rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
        @(negedge clk);
        if (result === 1'b1 && rdy === 1'b1) accepted++;
        total++; if (result !== 1'b0) begin bad++; $display("FAIL stall_after got=%0b exp=0", result); end
        total++; if (result_val !== 32'h12345000) begin bad++; $display("FAIL stall_val got=%h exp=12345000", result_val); end
        total++; if (accepted !== 1) begin bad++; $display("FAIL stall_count got=%0d exp=1", accepted); end
        drive(LUI, 3'b000, 1'b0, 32'd0, 32'd0, 32'hABCDE000, 32'h0, 4'd9);
        rdy = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if (result_val !== 32'h0 || result_rob_pos !== 4'd0) begin bad++; $display("FAIL rst_over_rdy got=%h/%0d exp=0/0", result_val, result_rob_pos); end
        rst = 1'b0; rdy = 1'b1; alu_en = 1'b0;
    endtask

    initial begin
        alu_en = 1'b0; alu_opcode = '0; alu_func3 = '0; alu_func1 = 1'b0;
        alu_val1 = '0; alu_val2 = '0; alu_imm = '0; alu_pc = '0; alu_rob_pos = '0;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        @(negedge clk);
        test_reset();
        test_sub_addi();
        test_shift_cmp();
        test_branch_jump();
        test_back_to_back();
        test_rdy_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
